// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and RGB332 field layout for the video clock domain.
package vga_timing_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // RGB332: red in the top three bits, blue in the bottom two.
   localparam int R_MSB = 7;
   localparam int R_LSB = 5;
   localparam int G_MSB = 4;
   localparam int G_LSB = 2;
   localparam int B_MSB = 1;
   localparam int B_LSB = 0;
endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register whose every stage resets asynchronously to RESET_VALUE.
module sync_delay_line #(
   parameter int               WIDTH       = 1,
   parameter int               DEPTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] delayed
);
   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VALUE;
      end else begin
         stages[0] <= data;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign delayed = stages[DEPTH-1];
endmodule

// File: rtl/vga_scanout.sv
// Free-running raster counter plus sync/de delay so VGA pins line up with renderer color.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter bit SYNC_POL    = 1'b0,
   parameter int COLOR_DELAY = 7,
   parameter int BPP         = 8
) (
   input  logic               clk,
   input  logic               reset,
   output logic signed [31:0] count_h,
   output logic signed [31:0] count_v,
   input  logic [BPP-1:0]     color_in,
   output logic               line_start,
   output logic               frame_start,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_de,
   output logic [2:0]         vga_r,
   output logic [2:0]         vga_g,
   output logic [1:0]         vga_b
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [2:0] IDLE_TIMING = {~SYNC_POL, ~SYNC_POL, 1'b0};

   logic       hs_raw;
   logic       vs_raw;
   logic       de_raw;
   logic [2:0] timing_raw;
   logic [2:0] timing_delayed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_h <= '0;
         count_v <= '0;
      end else if (count_h == H_TOTAL - 1) begin
         count_h <= '0;
         count_v <= (count_v == V_TOTAL - 1) ? '0 : count_v + 32'sd1;
      end else begin
         count_h <= count_h + 32'sd1;
      end
   end

   // Pulses are suppressed while reset is held so they cannot fire on the held-zero counts.
   assign line_start  = !reset && (count_h == 0);
   assign frame_start = !reset && (count_h == 0) && (count_v == 0);

   assign hs_raw = (count_h >= H_ACTIVE + H_FP && count_h < H_ACTIVE + H_FP + H_SYNC)
                   ? SYNC_POL : ~SYNC_POL;
   assign vs_raw = (count_v >= V_ACTIVE + V_FP && count_v < V_ACTIVE + V_FP + V_SYNC)
                   ? SYNC_POL : ~SYNC_POL;
   assign de_raw = (count_h < H_ACTIVE) && (count_v < V_ACTIVE);
   assign timing_raw = {hs_raw, vs_raw, de_raw};

   generate
      if (COLOR_DELAY == 0) begin : g_no_delay
         assign timing_delayed = timing_raw;
      end else begin : g_delay
         sync_delay_line #(
            .WIDTH      (3),
            .DEPTH      (COLOR_DELAY),
            .RESET_VALUE(IDLE_TIMING)
         ) u_delay (
            .clk    (clk),
            .reset  (reset),
            .data   (timing_raw),
            .delayed(timing_delayed)
         );
      end
   endgenerate

   // Final register joins the delayed timing with the renderer color that matches it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_hs <= ~SYNC_POL;
         vga_vs <= ~SYNC_POL;
         vga_de <= 1'b0;
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
      end else begin
         vga_hs <= timing_delayed[2];
         vga_vs <= timing_delayed[1];
         vga_de <= timing_delayed[0];
         if (timing_delayed[0]) begin
            vga_r <= color_in[R_MSB:R_LSB];
            vga_g <= color_in[G_MSB:G_LSB];
            vga_b <= color_in[B_MSB:B_LSB];
         end else begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
         end
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default, reduced-raster and zero-delay builds checked against an arithmetic model.
module tb_vga_scanout;
   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      int d;
   } cfg_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [7:0] rgb;
   } pins_t;

   localparam cfg_t C_DEF = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, d:7};
   localparam cfg_t C_SM  = '{ha:20, hfp:3, hs:5, hbp:4, va:6, vfp:2, vs:2, vbp:2, d:7};
   localparam cfg_t C_Z   = '{ha:20, hfp:3, hs:5, hbp:4, va:6, vfp:2, vs:2, vbp:2, d:0};
   localparam int SM_FRAME = 32 * 12;

   logic clk;
   logic rst;
   logic [7:0] color_in;
   logic [7:0] prev_col;
   int tt;
   int total;
   int bad;

   logic signed [31:0] d_ch, d_cv, s_ch, s_cv, z_ch, z_cv;
   logic d_ls, d_fs, d_hs, d_vs, d_de;
   logic s_ls, s_fs, s_hs, s_vs, s_de;
   logic z_ls, z_fs, z_hs, z_vs, z_de;
   logic [2:0] d_r, d_g, s_r, s_g, z_r, z_g;
   logic [1:0] d_b, s_b, z_b;

   vga_scanout u_def (
      .clk(clk), .reset(rst), .count_h(d_ch), .count_v(d_cv), .color_in(color_in),
      .line_start(d_ls), .frame_start(d_fs), .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de),
      .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
   );

   vga_scanout #(
      .H_ACTIVE(C_SM.ha), .H_FP(C_SM.hfp), .H_SYNC(C_SM.hs), .H_BP(C_SM.hbp),
      .V_ACTIVE(C_SM.va), .V_FP(C_SM.vfp), .V_SYNC(C_SM.vs), .V_BP(C_SM.vbp),
      .SYNC_POL(1'b0), .COLOR_DELAY(C_SM.d), .BPP(8)
   ) u_sm (
      .clk(clk), .reset(rst), .count_h(s_ch), .count_v(s_cv), .color_in(color_in),
      .line_start(s_ls), .frame_start(s_fs), .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
   );

   vga_scanout #(
      .H_ACTIVE(C_Z.ha), .H_FP(C_Z.hfp), .H_SYNC(C_Z.hs), .H_BP(C_Z.hbp),
      .V_ACTIVE(C_Z.va), .V_FP(C_Z.vfp), .V_SYNC(C_Z.vs), .V_BP(C_Z.vbp),
      .SYNC_POL(1'b0), .COLOR_DELAY(C_Z.d), .BPP(8)
   ) u_zero (
      .clk(clk), .reset(rst), .count_h(z_ch), .count_v(z_cv), .color_in(color_in),
      .line_start(z_ls), .frame_start(z_fs), .vga_hs(z_hs), .vga_vs(z_vs), .vga_de(z_de),
      .vga_r(z_r), .vga_g(z_g), .vga_b(z_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string name, input int t, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
      end
   endtask

   // Pins at cycle t show the raster position of cycle t-d-1; earlier they are still idle.
   function automatic pins_t exp_pins(input cfg_t c, input int t, input logic [7:0] pcol);
      pins_t p;
      int ht, vt, s, h, v;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      p.hs = 1'b1; p.vs = 1'b1; p.de = 1'b0; p.rgb = 8'h00;
      if (t >= c.d + 1) begin
         s = t - c.d - 1;
         h = s % ht;
         v = (s / ht) % vt;
         p.hs = !(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs);
         p.vs = !(v >= c.va + c.vfp && v < c.va + c.vfp + c.vs);
         p.de = (h < c.ha) && (v < c.va);
         p.rgb = p.de ? pcol : 8'h00;
      end
      return p;
   endfunction

   task automatic check_inst(input string nm, input cfg_t c, input int t, input bit in_rst,
                             input logic signed [31:0] ch, input logic signed [31:0] cv,
                             input logic ls, input logic fs, input logic hs, input logic vs,
                             input logic de, input logic [7:0] rgb, input logic [7:0] pcol);
      int ht, vt, eh, ev;
      pins_t p;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      if (in_rst) begin
         eh = 0; ev = 0;
         p.hs = 1'b1; p.vs = 1'b1; p.de = 1'b0; p.rgb = 8'h00;
      end else begin
         eh = t % ht;
         ev = (t / ht) % vt;
         p = exp_pins(c, t, pcol);
      end
      check_val({nm, ".count_h"}, t, ch, eh);
      check_val({nm, ".count_v"}, t, cv, ev);
      check_val({nm, ".line_start"}, t, ls, !in_rst && eh == 0);
      check_val({nm, ".frame_start"}, t, fs, !in_rst && eh == 0 && ev == 0);
      check_val({nm, ".vga_hs"}, t, hs, p.hs);
      check_val({nm, ".vga_vs"}, t, vs, p.vs);
      check_val({nm, ".vga_de"}, t, de, p.de);
      check_val({nm, ".rgb"}, t, rgb, p.rgb);
   endtask

   // Single compare process: every negedge, all three builds against the model.
   always @(negedge clk) begin
      check_inst("def", C_DEF, tt, rst, d_ch, d_cv, d_ls, d_fs, d_hs, d_vs, d_de, {d_r, d_g, d_b}, prev_col);
      check_inst("sm", C_SM, tt, rst, s_ch, s_cv, s_ls, s_fs, s_hs, s_vs, s_de, {s_r, s_g, s_b}, prev_col);
      check_inst("zero", C_Z, tt, rst, z_ch, z_cv, z_ls, z_fs, z_hs, z_vs, z_de, {z_r, z_g, z_b}, prev_col);
      if (rst) begin
         tt = 0;
      end else begin
         case (tt)
            0: begin
               check_val("lit.def_frame_start0", tt, d_fs, 1);
               check_val("lit.zero_de0", tt, z_de, 0);
            end
            1:   check_val("lit.zero_de1", tt, z_de, 1);
            7:   check_val("lit.def_de7", tt, d_de, 0);
            8:   check_val("lit.def_de8", tt, d_de, 1);
            263: check_val("lit.sm_vs263", tt, s_vs, 1);
            264: check_val("lit.sm_vs264", tt, s_vs, 0);
            327: check_val("lit.sm_vs327", tt, s_vs, 0);
            328: check_val("lit.sm_vs328", tt, s_vs, 1);
            384: check_val("lit.sm_frame_start384", tt, s_fs, 1);
            663: check_val("lit.def_hs663", tt, d_hs, 1);
            664: check_val("lit.def_hs664", tt, d_hs, 0);
            759: check_val("lit.def_hs759", tt, d_hs, 0);
            760: check_val("lit.def_hs760", tt, d_hs, 1);
            799: begin
               check_val("lit.def_h799", tt, d_ch, 799);
               check_val("lit.def_v799", tt, d_cv, 0);
            end
            800: begin
               check_val("lit.def_h800", tt, d_ch, 0);
               check_val("lit.def_v800", tt, d_cv, 1);
               check_val("lit.def_line_start800", tt, d_ls, 1);
            end
            default: ;
         endcase
         tt = tt + 1;
      end
      prev_col = color_in;
   end

   // Random renderer color, including full-white values that must be blanked.
   initial begin
      color_in = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         color_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      end
   end

   initial begin
      bit found;
      total = 0;
      bad = 0;
      tt = 0;
      prev_col = 8'h00;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2000) @(posedge clk);

      // Reset the reduced raster while its delayed hs and vs are both active.
      found = 1'b0;
      for (int i = 0; i < SM_FRAME + 8 && !found; i++) begin
         @(posedge clk);
         #1;
         if (tt % SM_FRAME == 319) found = 1'b1;
      end
      check_val("wait_reset_point", tt, found, 1);
      if (found) begin
         check_val("pre_reset.sm_hs", tt, s_hs, 0);
         check_val("pre_reset.sm_vs", tt, s_vs, 0);
         #1 rst = 1'b1;
         #1;
         check_val("async_reset.sm_hs", tt, s_hs, 1);
         check_val("async_reset.sm_vs", tt, s_vs, 1);
         check_val("async_reset.sm_count_h", tt, s_ch, 0);
         check_val("async_reset.sm_count_v", tt, s_cv, 0);
         repeat (3) @(posedge clk);
         #2 rst = 1'b0;
      end
      repeat (1000) @(posedge clk);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Pixel-clock timing generator that drives the ext_count_h/ext_count_v raster position consumed by the sprite and bitmap renderers.
- Accepts the renderers' 8-bit color back after their fixed pipeline delay.
- Emits VGA hsync/vsync/data-enable and RGB332 pins, all aligned to each other.
- Sits at the top of the video clock domain, one instance per display.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hs/vs (0 = active-low)
- COLOR_DELAY, 7, cycles from count presentation to matching color_in (>= 0)
- BPP, 8, color_in width

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- count_h  out  32 signed  current horizontal position, registered
- count_v  out  32 signed  current vertical position, registered
- color_in  in  BPP  renderer color for counts presented COLOR_DELAY cycles earlier
- line_start  out  1  one-cycle pulse, aligned with count_h==0
- frame_start  out  1  one-cycle pulse, aligned with count_h==0 && count_v==0
- vga_hs  out  1  horizontal sync, delayed
- vga_vs  out  1  vertical sync, delayed
- vga_de  out  1  data enable, delayed
- vga_r  out  3  red = color[7:5]
- vga_g  out  3  green = color[4:2]
- vga_b  out  2  blue = color[1:0]

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release):
  - count_h = count_v = 0.
  - line_start = frame_start = 0.
  - vga_hs = vga_vs = ~SYNC_POL.
  - vga_de = 0; vga_r/g/b = 0.
  - Every stage of the delay line resets to inactive values.
- Counters: count_h increments every clk. At H_TOTAL-1 it wraps to 0 and count_v increments. count_v wraps from V_TOTAL-1 to 0 on the same cycle count_h wraps. The upper bits of count_h/count_v are always zero; they are never negative.
- First cycle after reset release: count_h is still 0. line_start and frame_start are combinational decodes of the registered counts, so both pulse on that cycle.
- Raw timing, decoded from the registered counts:
  - hs_raw = SYNC_POL when H_ACTIVE+H_FP <= count_h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw = SYNC_POL when V_ACTIVE+V_FP <= count_v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - de_raw = (count_h < H_ACTIVE) && (count_v < V_ACTIVE).
- Alignment:
  - {hs_raw, vs_raw, de_raw} pass through a COLOR_DELAY-stage resettable shift register, then one output register.
  - color_in passes through one output register: vga_{r,g,b} <= de_delayed ? color_in fields : 0.
  - Net latency: every pin shows state for counts (h,v) exactly COLOR_DELAY+1 cycles after count_h/count_v showed (h,v).
  - COLOR_DELAY=0: the delay line is bypassed and latency is 1.
- Blanking: RGB is forced to 0 whenever the delayed de is 0, regardless of color_in.
- Reset mid-frame: counters return to 0 immediately and the delay line flushes to inactive. After release, no stale sync or de pulse appears.
- No back-pressure; the block free-runs.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - derived H_TOTAL/V_TOTAL;
  - RGB332 field positions.
- One sub-module, sync_delay_line (WIDTH, DEPTH, RESET_VALUE): async-reset shift register. It is used because shift_register_vector has no reset.

Test Plan:
- Reset then release -> count_h=count_v=0, frame_start=1 on first cycle; vga_hs=vga_vs=1, vga_de=0, rgb=0 until delayed signals arrive.
- Run 800 cycles -> count_h 0..799 then 0; count_v 0->1; line_start pulses at cycles 0 and 800; vga_hs low for exactly 96 cycles, falling 8 cycles after count_h==656.
- Run one full frame (420000 cycles) -> frame_start period 420000; vga_vs low for 1600 cycles, falling 8 cycles after (h=0,v=490); vga_de high for 640 of each 800 cycles on lines 0..479 only.
- Bench models renderer: color_in = count_h[7:0] delayed 7 cycles -> at each vga_de-high cycle, {vga_r,vga_g,vga_b} equals low 8 bits of the h-position being displayed (0x00, 0x01, ...); rgb=0 during blanking even with color_in=0xFF.
- Assert reset at (h=700,v=491) for 3 cycles -> counters 0 immediately; vga_hs/vga_vs return to 1 asynchronously; no low sync pulse within the next 8 cycles.
- COLOR_DELAY=0 build -> vga_de rises 1 cycle after count_h==0 on line 0.
